// File: rtl/oclib_uart_rx_deframer.sv
// UART 8N1 receive deframer: synchronizes the rx pin, qualifies start bits,
// samples each bit at mid-period, flags framing/break/overrun conditions and
// buffers received bytes in a small FIFO with a valid/ready output.
module oclib_uart_rx_deframer #(
   parameter int ClockHz    = 156_250_000,
   parameter int Baud       = 10_000_000,
   parameter int FifoDepth  = 4,
   parameter int SyncCycles = 3
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] outData,
   output logic       outValid,
   input  logic       outReady,
   output logic [2:0] error,
   input  logic       errorClear,
   output logic       rxActive
);

   localparam int CyclesPerBit = (ClockHz + Baud / 2) / Baud;
   localparam int HalfBit      = CyclesPerBit / 2;
   localparam int CntW         = $clog2(CyclesPerBit) + 1;
   localparam int PtrW         = $clog2(FifoDepth);

   localparam logic [CntW-1:0] CntBit  = CntW'(CyclesPerBit - 1);
   localparam logic [CntW-1:0] CntHalf = CntW'(HalfBit - 1);
   localparam logic [PtrW:0]   CntFull = (PtrW + 1)'(FifoDepth);

   if (CyclesPerBit < 4) begin : g_bad_bit_timing
      $error("oclib_uart_rx_deframer: ClockHz/Baud gives fewer than 4 cycles per bit");
   end
   if ((FifoDepth < 2) || ((FifoDepth & (FifoDepth - 1)) != 0)) begin : g_bad_fifo_depth
      $error("oclib_uart_rx_deframer: FifoDepth must be a power of two and at least 2");
   end
   if (SyncCycles < 2) begin : g_bad_sync
      $error("oclib_uart_rx_deframer: SyncCycles must be at least 2");
   end

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } state_t;

   logic [SyncCycles-1:0] sync_p;
   logic                  rx_sync;
   logic                  armed;
   logic [CntW-1:0]       arm_cnt;
   state_t                state;
   logic [CntW-1:0]       cnt;
   logic [2:0]            bit_idx;
   logic [7:0]            shift;

   logic                  stop_sample;
   logic                  push;
   logic                  pop;
   logic                  full;
   logic                  push_ok;
   logic                  frame_evt;
   logic                  break_evt;
   logic                  overrun_evt;

   logic [7:0]            mem [FifoDepth];
   logic [PtrW-1:0]       wr_ptr;
   logic [PtrW-1:0]       rd_ptr;
   logic [PtrW:0]         count;

   // Metastability chain; preset high so the line reads idle out of reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         sync_p <= '1;
      end else begin
         sync_p <= {sync_p[SyncCycles-2:0], rx};
      end
   end

   assign rx_sync = sync_p[SyncCycles-1];

   // Arm start detection only after one full bit time of idle line, so a
   // line stuck low across reset never produces a phantom byte.
   always_ff @(posedge clock) begin
      if (reset) begin
         armed   <= 1'b0;
         arm_cnt <= '0;
      end else if (!armed) begin
         if (!rx_sync) begin
            arm_cnt <= '0;
         end else if (arm_cnt == CntBit) begin
            armed <= 1'b1;
         end else begin
            arm_cnt <= arm_cnt + 1'b1;
         end
      end
   end

   assign stop_sample = (state == STOP) && (cnt == '0);
   assign push        = stop_sample && rx_sync;
   assign frame_evt   = stop_sample && !rx_sync && (shift != 8'h00);
   assign break_evt   = stop_sample && !rx_sync && (shift == 8'h00);

   // Frame sequencer: half-bit into the start bit, then one bit period per
   // data/stop sample so every decision lands mid-bit.
   always_ff @(posedge clock) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         rxActive <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (armed && !rx_sync) begin
                  cnt      <= CntHalf;
                  state    <= START;
                  rxActive <= 1'b1;
               end
            end
            START: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (rx_sync) begin
                  // Start bit did not survive to mid-bit: treat as a glitch.
                  state    <= IDLE;
                  rxActive <= 1'b0;
               end else begin
                  cnt     <= CntBit;
                  bit_idx <= '0;
                  state   <= DATA;
               end
            end
            DATA: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else begin
                  cnt <= CntBit;
                  if (bit_idx == 3'd7) begin
                     state <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
            STOP: begin
               if (cnt != '0) begin
                  cnt <= cnt - 1'b1;
               end else if (!rx_sync && (shift == 8'h00)) begin
                  cnt   <= CntBit;
                  state <= BREAK;
               end else begin
                  // Good stop or framing error: either way a low line here
                  // is allowed to start a new detect immediately.
                  state    <= IDLE;
                  rxActive <= 1'b0;
               end
            end
            BREAK: begin
               if (!rx_sync) begin
                  cnt <= CntBit;
               end else if (cnt == '0) begin
                  state    <= IDLE;
                  rxActive <= 1'b0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            default: begin
               state    <= IDLE;
               rxActive <= 1'b0;
            end
         endcase
      end
   end

   // LSB-first data shift at each mid-bit sample.
   always_ff @(posedge clock) begin
      if ((state == DATA) && (cnt == '0)) begin
         shift <= {rx_sync, shift[7:1]};
      end
   end

   assign full        = (count == CntFull);
   assign pop         = outValid && outReady;
   assign push_ok     = push && (!full || pop);
   assign overrun_evt = push && full && !pop;

   // FIFO storage; a pop in the same cycle makes room for a push when full.
   always_ff @(posedge clock) begin
      if (push_ok) begin
         mem[wr_ptr] <= shift;
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign outValid = (count != '0);
   assign outData  = outValid ? mem[rd_ptr] : 8'h00;

   // Sticky error flags; a new event outranks a same-cycle clear.
   always_ff @(posedge clock) begin
      if (reset) begin
         error <= '0;
      end else begin
         error <= (errorClear ? 3'b000 : error) | {break_evt, overrun_evt, frame_evt};
      end
   end

endmodule

// File: tb/tb_oclib_uart_rx_deframer.sv
// Testbench for oclib_uart_rx_deframer: frame-level reference model with a
// per-cycle comparison of outValid/outData/error, plus directed scenarios.
module tb_oclib_uart_rx_deframer;

   localparam int ClockHz    = 156_250_000;
   localparam int Baud       = 10_000_000;
   localparam int FifoDepth  = 4;
   localparam int SyncCycles = 3;
   localparam int Cpb        = (ClockHz + Baud / 2) / Baud;
   localparam int Half       = Cpb / 2;
   // Line falls after edge n -> byte visible after edge n + Lat.
   localparam int Lat        = SyncCycles + 1 + Half + 9 * Cpb;

   localparam int EvPush  = 0;
   localparam int EvFrame = 1;
   localparam int EvBreak = 2;

   typedef struct {
      int         cyc;
      int         kind;
      logic [7:0] d;
   } ev_t;

   logic       clock = 1'b0;
   logic       reset;
   logic       rx;
   logic [7:0] outData;
   logic       outValid;
   logic       outReady;
   logic [2:0] error;
   logic       errorClear;
   logic       rxActive;

   int         vectors = 0;
   int         miscompares = 0;
   int         edge_n = 0;
   bit         started = 1'b0;
   bit         rand_ready = 1'b0;
   bit         prev_valid = 1'b0;

   logic [7:0] mq[$];
   ev_t        ev[$];
   logic [2:0] merr = 3'b000;
   logic [7:0] popped[$];
   int         rise_q[$];

   oclib_uart_rx_deframer #(
      .ClockHz   (ClockHz),
      .Baud      (Baud),
      .FifoDepth (FifoDepth),
      .SyncCycles(SyncCycles)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .rx        (rx),
      .outData   (outData),
      .outValid  (outValid),
      .outReady  (outReady),
      .error     (error),
      .errorClear(errorClear),
      .rxActive  (rxActive)
   );

   always #5 clock = ~clock;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at edge %0d: got %0h, expected %0h", nm, edge_n, act, exp);
      end
   endtask

   // Reference model, advanced once per rising edge using pre-edge inputs.
   initial begin
      ev_t        e;
      logic [2:0] nerr;
      forever begin
         @(posedge clock);
         edge_n++;
         if (reset) begin
            mq.delete();
            ev.delete();
            merr    = 3'b000;
            started = 1'b1;
         end else if (started) begin
            if (outValid && outReady) popped.push_back(outData);
            nerr = errorClear ? 3'b000 : merr;
            if (mq.size() != 0 && outReady) mq.delete(0);
            while (ev.size() != 0 && ev[0].cyc <= edge_n) begin
               e = ev[0];
               ev.delete(0);
               case (e.kind)
                  EvPush: begin
                     if (mq.size() < FifoDepth) mq.push_back(e.d);
                     else nerr[1] = 1'b1;
                  end
                  EvFrame: nerr[0] = 1'b1;
                  default: nerr[2] = 1'b1;
               endcase
            end
            merr = nerr;
         end
      end
   end

   // Per-cycle compare on the falling edge.
   initial begin
      forever begin
         @(negedge clock);
         if (started) begin
            chk("outValid", 32'(outValid), 32'(mq.size() != 0));
            if (mq.size() != 0) chk("outData", 32'(outData), 32'(mq[0]));
            chk("error", 32'(error), 32'(merr));
            if (outValid && !prev_valid) rise_q.push_back(edge_n);
            prev_valid = outValid;
         end
      end
   end

   // Random consumer back-pressure.
   initial begin
      forever begin
         @(posedge clock);
         #1;
         if (rand_ready) outReady = 1'($urandom_range(0, 1));
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   task automatic wait_cyc(input int k);
      repeat (k) @(posedge clock);
      #1;
   endtask

   task automatic idle(input int k);
      rx = 1'b1;
      wait_cyc(k);
   endtask

   // Drive one 10-bit frame (start, 8 data LSB-first, stop) and record what
   // the receiver must report for it. Leaves rx at the stop-bit level.
   task automatic send(input logic [7:0] d, input logic stop, output int n);
      logic [9:0] bits;
      ev_t        e;
      bits = {stop, d, 1'b0};
      @(posedge clock);
      #1;
      n     = edge_n;
      e.cyc = n + Lat;
      e.d   = d;
      if (stop) e.kind = EvPush;
      else if (d == 8'h00) e.kind = EvBreak;
      else e.kind = EvFrame;
      ev.push_back(e);
      for (int j = 0; j < 10; j++) begin
         rx = bits[j];
         wait_cyc(Cpb);
      end
   endtask

   task automatic pulse_clear();
      errorClear = 1'b1;
      wait_cyc(1);
      errorClear = 1'b0;
   endtask

   initial begin
      int         n;
      int         st[3];
      logic [7:0] exp1[3];
      logic [7:0] d;
      logic       stp;
      exp1 = '{8'h55, 8'hA3, 8'h7E};
      reset = 1'b1;
      rx = 1'b1;
      outReady = 1'b0;
      errorClear = 1'b0;
      wait_cyc(4);
      chk("reset_outValid", 32'(outValid), 32'd0);
      chk("reset_outData", 32'(outData), 32'd0);
      chk("reset_error", 32'(error), 32'd0);
      chk("reset_rxActive", 32'(rxActive), 32'd0);
      reset = 1'b0;
      idle(40);

      // Three bytes with a ready consumer.
      popped.delete();
      rise_q.delete();
      outReady = 1'b1;
      foreach (exp1[i]) begin
         send(exp1[i], 1'b1, n);
         st[i] = n;
      end
      idle(20);
      chk("t1_count", 32'(popped.size()), 32'd3);
      chk("t1_rises", 32'(rise_q.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < popped.size()) chk("t1_byte", 32'(popped[i]), 32'(exp1[i]));
         if (i < rise_q.size()) chk("t1_latency", 32'(rise_q[i] - st[i]), 32'd156);
      end
      chk("t1_error", 32'(error), 32'd0);

      // Overflow: six bytes into a four-deep FIFO with no consumer.
      outReady = 1'b0;
      for (int i = 1; i <= 6; i++) send(8'(i), 1'b1, n);
      idle(20);
      chk("t2_error", 32'(error), 32'b010);
      chk("t2_head", 32'(outData), 32'h01);
      popped.delete();
      outReady = 1'b1;
      wait_cyc(12);
      chk("t2_count", 32'(popped.size()), 32'd4);
      for (int i = 0; i < 4; i++)
         if (i < popped.size()) chk("t2_byte", 32'(popped[i]), 32'(i + 1));
      pulse_clear();
      chk("t2_cleared", 32'(error), 32'd0);

      // Short low glitch while idle.
      popped.delete();
      idle(20);
      rx = 1'b0;
      wait_cyc(5);
      rx = 1'b1;
      chk("t3_active", 32'(rxActive), 32'd1);
      wait_cyc(8);
      chk("t3_idle", 32'(rxActive), 32'd0);
      idle(20);
      chk("t3_nobyte", 32'(popped.size()), 32'd0);
      chk("t3_error", 32'(error), 32'd0);

      // Framing error, then break, then a clean byte.
      send(8'h3C, 1'b0, n);
      idle(40);
      chk("t4_framing", 32'(error), 32'b001);
      pulse_clear();
      send(8'h00, 1'b0, n);
      wait_cyc(10 * Cpb);
      idle(32);
      chk("t4_break", 32'(error), 32'b100);
      send(8'h41, 1'b1, n);
      idle(20);
      chk("t4_count", 32'(popped.size()), 32'd1);
      if (popped.size() > 0) chk("t4_byte", 32'(popped[0]), 32'h41);

      // Line held low through reset and beyond.
      popped.delete();
      rx = 1'b0;
      reset = 1'b1;
      wait_cyc(4);
      reset = 1'b0;
      wait_cyc(3 * Cpb);
      chk("t5_nobyte", 32'(outValid), 32'd0);
      chk("t5_error", 32'(error), 32'd0);
      idle(Cpb - 1);
      send(8'h0D, 1'b1, n);
      idle(20);
      chk("t5_count", 32'(popped.size()), 32'd1);
      if (popped.size() > 0) chk("t5_byte", 32'(popped[0]), 32'h0D);

      // Reset in the middle of data bit 4 with two bytes buffered.
      outReady = 1'b0;
      send(8'h11, 1'b1, n);
      send(8'h22, 1'b1, n);
      idle(4);
      chk("t6_head", 32'(outData), 32'h11);
      d = 8'h33;
      rx = 1'b0;
      wait_cyc(Cpb);
      for (int j = 0; j < 4; j++) begin
         rx = d[j];
         wait_cyc(Cpb);
      end
      rx = d[4];
      wait_cyc(Half);
      reset = 1'b1;
      rx = 1'b1;
      wait_cyc(1);
      chk("t6_flushed", 32'(outValid), 32'd0);
      chk("t6_rxActive", 32'(rxActive), 32'd0);
      reset = 1'b0;
      idle(40);
      popped.delete();
      outReady = 1'b1;
      send(8'h0A, 1'b1, n);
      idle(20);
      chk("t6_count", 32'(popped.size()), 32'd1);
      if (popped.size() > 0) chk("t6_byte", 32'(popped[0]), 32'h0A);

      // Randomized traffic with random back-pressure and clears.
      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         d   = 8'($urandom);
         stp = ($urandom_range(0, 7) != 0);
         send(d, stp, n);
         if (stp) idle($urandom_range(0, 20));
         else idle($urandom_range(32, 60));
         if ($urandom_range(0, 3) == 0) pulse_clear();
      end
      rand_ready = 1'b0;
      outReady = 1'b1;
      idle(200);
      chk("final_drained", 32'(outValid), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
